// File: rtl/mole_spawner.sv
// mole_spawner: LFSR-driven mole picker with ready handshake plus a per-level hit window timer.
module mole_spawner #(
  parameter int          CLK_FREQ_HZ = 50_000_000,
  parameter int          NUM_LEDS    = 18,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_1234,
  parameter int          WIN_L0_MS   = 2000,
  parameter int          WIN_L1_MS   = 1500,
  parameter int          WIN_L2_MS   = 1000,
  parameter int          WIN_L3_MS   = 600,
  parameter int          MAX_RETRY   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ready_for_mole,
  input  logic                timeout_start,
  input  logic [2:0]          level_select,
  output logic                rng_ready,
  output logic [NUM_LEDS-1:0] led_number,
  output logic                timeout
);
  localparam int MS_TICKS = CLK_FREQ_HZ / 1000;
  localparam int PW = MS_TICKS > 1 ? $clog2(MS_TICKS) : 1;
  localparam int LW = $clog2(NUM_LEDS + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [31:0] TAPS = 32'h8020_0003;
  typedef enum logic [1:0] {G_IDLE, G_DRAW, G_PRESENT} g_state_t;
  g_state_t state, state_n;
  logic [31:0] lfsr;
  logic [LW-1:0] last_index, fallback, pick;
  logic [RW-1:0] retry;
  logic [4:0] cand;
  logic valid, exhausted, accept;
  logic start_d;
  logic [15:0] remaining_ms, window;
  logic [PW-1:0] presc;
  always_comb begin
    cand = lfsr[4:0];
    valid = (32'(cand) < NUM_LEDS) && (32'(cand) != 32'(last_index));
    exhausted = retry == RW'(MAX_RETRY);
    fallback = (32'(last_index) >= NUM_LEDS - 1) ? '0 : last_index + 1'b1;
    pick = exhausted ? fallback : LW'(cand);
    accept = (state == G_DRAW) && (exhausted || valid);
    state_n = state == G_IDLE ? (ready_for_mole ? G_DRAW : G_IDLE) :
              state == G_DRAW ? (accept ? G_PRESENT : G_DRAW) :
              (ready_for_mole ? G_PRESENT : G_IDLE);
    window = level_select == 3'b001 ? 16'(WIN_L1_MS) :
             level_select == 3'b010 ? 16'(WIN_L2_MS) :
             level_select == 3'b100 ? 16'(WIN_L3_MS) : 16'(WIN_L0_MS);
  end
  // The LFSR runs every cycle so request timing perturbs which value gets sampled.
  always_ff @(posedge clk) begin
    lfsr <= reset ? LFSR_SEED : ({1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0));
    if (reset) begin
      state <= G_IDLE;
      last_index <= LW'(NUM_LEDS);
      retry <= '0;
      led_number <= '0;
      rng_ready <= 1'b0;
    end else begin
      state <= state_n;
      rng_ready <= state_n == G_PRESENT;
      retry <= (state == G_DRAW && !accept) ? retry + 1'b1 : '0;
      if (accept) begin
        led_number <= NUM_LEDS'(1) << pick;
        last_index <= pick;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      start_d <= 1'b0;
      remaining_ms <= '0;
      presc <= '0;
      timeout <= 1'b1;
    end else begin
      start_d <= timeout_start;
      if (timeout_start && !start_d) begin
        remaining_ms <= window;
        presc <= '0;
        timeout <= 1'b1;
      end else if (!timeout_start) begin
        timeout <= 1'b1;
      end else if (remaining_ms != 16'd0) begin
        if (presc == PW'(MS_TICKS - 1)) begin
          presc <= '0;
          remaining_ms <= remaining_ms - 16'd1;
          if (remaining_ms == 16'd1) timeout <= 1'b0;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end
endmodule
